// File: rtl/imem_prog_loader_pkg.sv
// +----------------------------------------------------------------------+
// | loader_pkg : shared types and constants for the imem program loader  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_CHECK = 3'd3,
      ST_RUN   = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef logic [1:0] lane_t;

endpackage

`default_nettype wire

// File: rtl/imem_prog_loader_byte_packer.sv
// +----------------------------------------------------------------------+
// | byte_packer : assembles four little-endian bytes into a 32-bit word  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_byte,
   input  logic        strobe,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_done
);

   lane_t       lane;
   logic [23:0] low_bytes;

   // The incoming byte is merged combinationally so the full word is
   // available in the same cycle as the 4th byte.
   always_comb begin
      word = {8'h00, low_bytes};
      word[{lane, 3'b000} +: 8] = in_byte;
   end

   assign word_done = strobe && (lane == 2'd3);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         lane      <= 2'd0;
         low_bytes <= 24'h0;
      end else if (strobe) begin
         lane      <= lane + 2'd1;
         low_bytes <= word[23:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_prog_loader.sv
// +----------------------------------------------------------------------+
// | imem_prog_loader : framed byte-stream loader for instruction memory  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_prog_loader
   import loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);

   localparam logic [8:0] DEPTH_LIMIT = 9'(IMEM_DEPTH);

   state_t            state, next_state;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        words_left;
   logic [7:0]        csum;
   logic              accept;
   logic              pack_strobe;
   logic              pack_clear;
   logic [31:0]       pack_word;
   logic              pack_done;

   assign s_ready   = reset && (state != ST_RUN);
   assign accept    = s_valid && s_ready;
   assign done      = (state == ST_RUN);
   assign core_hold = !done;

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .in_byte   (s_data),
      .strobe    (pack_strobe),
      .clear     (pack_clear),
      .word      (pack_word),
      .word_done (pack_done)
   );

   always_comb begin
      next_state  = state;
      pack_strobe = 1'b0;
      pack_clear  = 1'b0;
      case (state)
         ST_IDLE, ST_ERROR: begin
            if (accept && s_data == SYNC_BYTE)
               next_state = ST_COUNT;
         end
         ST_COUNT: begin
            if (accept) begin
               pack_clear = 1'b1;
               if (s_data == 8'd0 || {1'b0, s_data} > DEPTH_LIMIT)
                  next_state = ST_ERROR;
               else
                  next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            pack_strobe = accept;
            if (pack_done && words_left == 8'd1)
               next_state = ST_CHECK;
         end
         ST_CHECK: begin
            if (accept)
               next_state = (s_data == csum) ? ST_RUN : ST_ERROR;
         end
         ST_RUN:  next_state = ST_RUN;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         addr       <= '0;
         words_left <= 8'd0;
         csum       <= 8'd0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0;
         error      <= 1'b0;
      end else begin
         state   <= next_state;
         imem_we <= pack_done;
         if (state == ST_COUNT && accept) begin
            addr       <= '0;
            words_left <= s_data;
            csum       <= 8'd0;
         end
         if (pack_strobe)
            csum <= csum ^ s_data;
         if (pack_done) begin
            imem_addr  <= addr;
            imem_wdata <= pack_word;
            addr       <= addr + 1'b1;
            words_left <= words_left - 8'd1;
         end
         // Sticky across new frames; only a successful load clears it.
         if (next_state == ST_ERROR)
            error <= 1'b1;
         else if (next_state == ST_RUN)
            error <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: frame table plus corner sequences.
`default_nettype none

module tb_imem_prog_loader;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          done;
   logic          error;

   imem_prog_loader #(.IMEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   typedef struct {
      int          n;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          bad;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   wr_t  exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   wcount   = 0;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write monitor: every imem_we pulse is matched against the scoreboard.
   always begin
      @(posedge clk);
      #1;
      if (imem_we === 1'b1) begin
         wr_t e;
         wcount++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(imem_addr), 32'(e.a));
            chk("write_data", imem_wdata, e.d);
         end
      end
   end

   function automatic logic [31:0] word_at(input logic [31:0] w0, input logic [31:0] w1, input int i);
      if (i == 0) return w0;
      if (i == 1) return w1;
      return w0 ^ (32'(i) * 32'h9E37_79B9);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gapmax);
      int g;
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (g > 0) begin
         repeat (g) @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic run_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input bit bad, input int gapmax, input bit skip_sync);
      logic [7:0]  cs;
      logic [31:0] w;
      cs = 8'h00;
      if (!skip_sync) send_byte(8'hA5, gapmax);
      send_byte(8'(n), gapmax);
      if (n >= 1 && n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            w = word_at(w0, w1, i);
            exp_q.push_back('{a: AW'(i), d: w});
            for (int k = 0; k < 4; k++) begin
               send_byte(w[8*k +: 8], gapmax);
               cs = cs ^ w[8*k +: 8];
            end
         end
         chk("done_before_checksum", 32'(done), 32'd0);
         send_byte(bad ? (cs ^ 8'h5A) : cs, gapmax);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_core_hold", 32'(core_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
   endtask

   initial begin
      vecs[0] = '{n: 2,  w0: 32'h0010_0013, w1: 32'h0050_0093, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{n: 2,  w0: 32'h0010_0013, w1: 32'h0050_0093, bad: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{n: 0,  w0: 32'h0,         w1: 32'h0,         bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
      vecs[3] = '{n: 65, w0: 32'h0,         w1: 32'h0,         bad: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
      vecs[4] = '{n: 64, w0: 32'hDEAD_BEEF, w1: 32'h1234_5678, bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[5] = '{n: 1,  w0: 32'h8000_0001, w1: 32'h0,         bad: 1'b0, exp_done: 1'b1, exp_err: 1'b0};

      for (int v = 0; v < 6; v++) begin
         do_reset();
         wcount = 0;
         run_frame(vecs[v].n, vecs[v].w0, vecs[v].w1, vecs[v].bad, 0, 1'b0);
         chk("tbl_done", 32'(done), 32'(vecs[v].exp_done));
         chk("tbl_core_hold", 32'(core_hold), 32'(!vecs[v].exp_done));
         chk("tbl_error", 32'(error), 32'(vecs[v].exp_err));
         chk("tbl_s_ready", 32'(s_ready), 32'(!vecs[v].exp_done));
         chk("tbl_writes", 32'(wcount), (vecs[v].n >= 1 && vecs[v].n <= DEPTH) ? 32'(vecs[v].n) : 32'd0);
         chk("tbl_queue_empty", 32'(exp_q.size()), 32'd0);
      end

      // Bad checksum, then a good frame: error survives the new sync, clears on load.
      do_reset();
      run_frame(2, 32'h0010_0013, 32'h0050_0093, 1'b1, 0, 1'b0);
      chk("bad_cs_error", 32'(error), 32'd1);
      send_byte(8'hA5, 0);
      chk("error_held_new_frame", 32'(error), 32'd1);
      run_frame(2, 32'h0010_0013, 32'h0050_0093, 1'b0, 0, 1'b1);
      chk("reload_done", 32'(done), 32'd1);
      chk("reload_error", 32'(error), 32'd0);

      // Junk before sync.
      do_reset();
      wcount = 0;
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 0);
      chk("junk_no_write", 32'(wcount), 32'd0);
      chk("junk_no_error", 32'(error), 32'd0);
      run_frame(1, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 1'b0);
      chk("junk_done", 32'(done), 32'd1);
      chk("junk_writes", 32'(wcount), 32'd1);

      // Random gaps; then RUN must ignore further traffic.
      do_reset();
      wcount = 0;
      run_frame(2, 32'h0010_0013, 32'h0050_0093, 1'b0, 5, 1'b0);
      chk("gap_done", 32'(done), 32'd1);
      chk("gap_writes", 32'(wcount), 32'd2);
      s_valid = 1'b1;
      s_data  = 8'hA5;
      repeat (4) @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("run_stays_done", 32'(done), 32'd1);
      chk("run_s_ready", 32'(s_ready), 32'd0);
      chk("run_no_write", 32'(wcount), 32'd2);

      // Reset after the 6th byte of a frame.
      do_reset();
      wcount = 0;
      exp_q.push_back('{a: AW'(0), d: 32'h0010_0013});
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h10, 0);
      send_byte(8'h00, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_we", 32'(imem_we), 32'd0);
      chk("mid_rst_addr", 32'(imem_addr), 32'd0);
      chk("mid_rst_wdata", imem_wdata, 32'd0);
      chk("mid_rst_core_hold", 32'(core_hold), 32'd1);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
      chk("mid_rst_first_write", 32'(wcount), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      wcount = 0;
      run_frame(2, 32'h0010_0013, 32'h0050_0093, 1'b0, 0, 1'b0);
      chk("after_rst_done", 32'(done), 32'd1);
      chk("after_rst_writes", 32'(wcount), 32'd2);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
